// File: rtl/rsa_pkg.sv
// Shared types for the RSA decryptor: multiplier op codes and the ModExp
// sequencer state and step encodings.
package rsa_pkg;

  localparam int EXP_W_DEFAULT = 4096;

  typedef enum logic [1:0] {
    OP_ONE  = 2'd0,
    OP_COPY = 2'd1,
    OP_SQR  = 2'd2,
    OP_MUL  = 2'd3
  } mul_op_e;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SCAN  = 3'd1,
    ISSUE = 3'd2,
    WAIT  = 3'd3,
    FIN   = 3'd4
  } modexp_state_e;

  // What to do once the outstanding op completes
  typedef enum logic [1:0] {
    STEP_NEXT = 2'd0,
    STEP_CHK  = 2'd1,
    STEP_FIN  = 2'd2
  } next_step_e;

endpackage

// File: rtl/modexp_ctrl_chk.sv
// Protocol checker for the ModExp sequencer <-> modular-multiplier handshake.
// Bound alongside modexp_ctrl in simulation; holds no design state.
module modexp_ctrl_chk (
  input logic       clk,
  input logic       rst,
  input logic       abort_i,
  input logic       mul_valid_o,
  input logic       mul_ready_i,
  input logic       mul_done_i,
  input logic [1:0] mul_op_o
);

  logic pending_r;

  // Tracks whether the datapath still owes a completion pulse (survives abort)
  always_ff @(posedge clk) begin
    if (rst) begin
      pending_r <= 1'b0;
    end else if (mul_valid_o && mul_ready_i) begin
      pending_r <= 1'b1;
    end else if (mul_done_i) begin
      pending_r <= 1'b0;
    end else begin
      pending_r <= pending_r;
    end
  end

  a_done_has_op: assert property (@(posedge clk) disable iff (rst)
    mul_done_i |-> pending_r);

  a_one_outstanding: assert property (@(posedge clk) disable iff (rst)
    mul_valid_o |-> !pending_r);

  a_hold_while_stalled: assert property (@(posedge clk) disable iff (rst)
    (mul_valid_o && !mul_ready_i && !abort_i) |=> (mul_valid_o && $stable(mul_op_o)));

endmodule

// File: rtl/modexp_ctrl.sv
// Left-to-right square-and-multiply sequencer for R = B^E mod N. Scans the
// latched exponent MSB->LSB and issues one op at a time to the shared multiplier.
module modexp_ctrl
  import rsa_pkg::*;
#(
  parameter int EXP_W = EXP_W_DEFAULT,
  parameter int IDX_W = $clog2(EXP_W)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic             abort_i,
  input  logic [EXP_W-1:0] exp_i,
  output logic             busy_o,
  output logic             done_o,
  output logic             mul_valid_o,
  input  logic             mul_ready_i,
  output logic [1:0]       mul_op_o,
  input  logic             mul_done_i,
  output logic [IDX_W-1:0] bit_idx_o
);

  localparam logic [IDX_W-1:0] IDX_MAX  = IDX_W'(EXP_W - 1);
  localparam logic [IDX_W-1:0] IDX_ZERO = {IDX_W{1'b0}};
  localparam logic [IDX_W-1:0] IDX_ONE  = {{(IDX_W-1){1'b0}}, 1'b1};

  modexp_state_e    state_r, state_s;
  next_step_e       step_r, step_s;
  logic [EXP_W-1:0] exp_r, exp_s;
  logic [IDX_W-1:0] idx_r, idx_s;
  logic             busy_r, busy_s;
  logic             done_r, done_s;
  logic             valid_r, valid_s;
  mul_op_e          op_r, op_s;

  logic exp_bit_s;
  logic idx_zero_s;
  logic go_mul_s, go_sqr_s, go_fin_s;
  logic clear_s;

  assign exp_bit_s  = exp_r[idx_r];
  assign idx_zero_s = (idx_r == IDX_ZERO);

  // Decide the follow-up action for the op that is about to complete
  always_comb begin
    go_mul_s = 1'b0;
    go_sqr_s = 1'b0;
    go_fin_s = 1'b0;
    case (step_r)
      STEP_NEXT: begin
        if (idx_zero_s) begin
          go_fin_s = 1'b1;
        end else begin
          go_sqr_s = 1'b1;
        end
      end
      STEP_CHK: begin
        if (exp_bit_s) begin
          go_mul_s = 1'b1;
        end else if (idx_zero_s) begin
          go_fin_s = 1'b1;
        end else begin
          go_sqr_s = 1'b1;
        end
      end
      STEP_FIN: go_fin_s = 1'b1;
      default: begin
        go_fin_s = 1'b0;
      end
    endcase
  end

  // Next-state and next-output logic; abort and corrupt encodings collapse to IDLE
  always_comb begin
    state_s = state_r;
    step_s  = step_r;
    exp_s   = exp_r;
    idx_s   = idx_r;
    busy_s  = busy_r;
    done_s  = 1'b0;
    valid_s = valid_r;
    op_s    = op_r;
    clear_s = 1'b0;

    if (abort_i && (state_r != IDLE)) begin
      clear_s = 1'b1;
    end else begin
      case (state_r)
        IDLE: begin
          if (start_i) begin
            exp_s   = exp_i;
            idx_s   = IDX_MAX;
            busy_s  = 1'b1;
            state_s = SCAN;
          end else begin
            state_s = IDLE;
          end
        end
        SCAN: begin
          if (exp_bit_s) begin
            valid_s = 1'b1;
            op_s    = OP_COPY;
            step_s  = STEP_NEXT;
            state_s = ISSUE;
          end else if (!idx_zero_s) begin
            idx_s = idx_r - IDX_ONE;
          end else begin
            valid_s = 1'b1;
            op_s    = OP_ONE;
            step_s  = STEP_FIN;
            state_s = ISSUE;
          end
        end
        ISSUE: begin
          if (mul_ready_i) begin
            valid_s = 1'b0;
            state_s = WAIT;
          end else begin
            valid_s = 1'b1;
          end
        end
        WAIT: begin
          if (!mul_done_i) begin
            state_s = WAIT;
          end else if (go_mul_s) begin
            valid_s = 1'b1;
            op_s    = OP_MUL;
            step_s  = STEP_NEXT;
            state_s = ISSUE;
          end else if (go_sqr_s) begin
            idx_s   = idx_r - IDX_ONE;
            valid_s = 1'b1;
            op_s    = OP_SQR;
            step_s  = STEP_CHK;
            state_s = ISSUE;
          end else if (go_fin_s) begin
            done_s  = 1'b1;
            state_s = FIN;
          end else begin
            clear_s = 1'b1;
          end
        end
        FIN: begin
          busy_s  = 1'b0;
          state_s = IDLE;
        end
        default: clear_s = 1'b1;
      endcase
    end

    if (clear_s) begin
      state_s = IDLE;
      step_s  = STEP_NEXT;
      exp_s   = {EXP_W{1'b0}};
      idx_s   = IDX_MAX;
      busy_s  = 1'b0;
      done_s  = 1'b0;
      valid_s = 1'b0;
      op_s    = OP_ONE;
    end else begin
      done_s = done_s;
    end
  end

  // State, exponent, index and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
      step_r  <= STEP_NEXT;
      exp_r   <= {EXP_W{1'b0}};
      idx_r   <= IDX_MAX;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
      valid_r <= 1'b0;
      op_r    <= OP_ONE;
    end else begin
      state_r <= state_s;
      step_r  <= step_s;
      exp_r   <= exp_s;
      idx_r   <= idx_s;
      busy_r  <= busy_s;
      done_r  <= done_s;
      valid_r <= valid_s;
      op_r    <= op_s;
    end
  end

  assign busy_o      = busy_r;
  assign done_o      = done_r;
  assign mul_valid_o = valid_r;
  assign mul_op_o    = op_r;
  assign bit_idx_o   = idx_r;

endmodule
